// File: rtl/comparator_scan_sequencer_pkg.sv
// Shared types for the comparator scan sequencer: FSM states, bus widths, mask helpers.
package comparator_scan_sequencer_pkg;

  localparam int unsigned STRIP_W = 4;
  localparam int unsigned HS_W    = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FIRE    = 3'd2,
    S_RELEASE = 3'd3,
    S_SETTLE  = 3'd4,
    S_REPORT  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // Strip s owns halfstrips 2s and 2s+1.
  function automatic logic [HS_W-1:0] strip_mask(input logic [STRIP_W-1:0] s);
    return {{(HS_W-2){1'b0}}, 2'b11} << {s, 1'b0};
  endfunction

  function automatic logic [HS_W-1:0] expect_mask(input logic [STRIP_W-1:0] s,
                                                  input logic side);
    return {{(HS_W-1){1'b0}}, 1'b1} << {s, side};
  endfunction

endpackage

// File: rtl/comparator_scan_sequencer_scan_result_reg.sv
// Per-strip result record: saturating capture of the injector error counters,
// held stable under a valid/ready handshake until accepted or cleared.
module scan_result_reg
  import comparator_scan_sequencer_pkg::*;
#(
  parameter int unsigned RES_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [STRIP_W-1:0] strip,
  input  logic [31:0]        thr_cnt,
  input  logic [31:0]        off_cnt,
  input  logic [31:0]        cmp_cnt,
  input  logic               wdog,
  input  logic               ready,
  output logic               valid,
  output logic [STRIP_W-1:0] res_strip,
  output logic [RES_W-1:0]   res_thr_err,
  output logic [RES_W-1:0]   res_off_err,
  output logic [RES_W-1:0]   res_cmp_err,
  output logic               res_wdog
);

  function automatic logic [RES_W-1:0] sat(input logic [31:0] c);
    return ((c >> RES_W) != 32'd0) ? '1 : c[RES_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      res_strip   <= '0;
      res_thr_err <= '0;
      res_off_err <= '0;
      res_cmp_err <= '0;
      res_wdog    <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load && !valid) begin
      valid       <= 1'b1;
      res_strip   <= strip;
      res_thr_err <= sat(thr_cnt);
      res_off_err <= sat(off_cnt);
      res_cmp_err <= sat(cmp_cnt);
      res_wdog    <= wdog;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/comparator_scan_sequencer.sv
// Walks a strip range, fires N injector pulses per strip and reports error counts per strip.
// Optional pulser-handshake watchdog enabled by defining SCAN_WDOG_EN.
module comparator_scan_sequencer
  import comparator_scan_sequencer_pkg::*;
#(
  parameter int unsigned N_STRIPS   = 16,
  parameter int unsigned RES_W      = 16,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned WDOG_CYC   = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [STRIP_W-1:0] first_strip,
  input  logic [STRIP_W-1:0] last_strip,
  input  logic [15:0]        n_pulses,
  input  logic               hs_side,
  output logic               busy,
  output logic               done,
  output logic               fire_pulse,
  input  logic               pulser_ready,
  output logic [HS_W-1:0]    active_strip_mask,
  output logic [HS_W-1:0]    halfstrips_expect,
  output logic               errcnt_rst,
  input  logic [31:0]        thresholds_errcnt,
  input  logic [31:0]        offsets_errcnt,
  input  logic [31:0]        compout_errcnt,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [STRIP_W-1:0] res_strip,
  output logic [RES_W-1:0]   res_thr_err,
  output logic [RES_W-1:0]   res_off_err,
  output logic [RES_W-1:0]   res_cmp_err,
  output logic               res_wdog
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);

  state_t             state;
  logic [STRIP_W-1:0] strip;
  logic [STRIP_W-1:0] last_lat;
  logic [15:0]        pulse_cnt;
  logic [15:0]        pulse_last;
  logic               hs_lat;
  logic [SET_W-1:0]   settle_cnt;
  logic               settle_done;
  logic               wdog_trip;
  logic               last_of_scan;

  assign settle_done  = (state == S_SETTLE) && (settle_cnt == SET_W'(SETTLE_CYC - 1));
  assign last_of_scan = (strip == last_lat) || (strip == STRIP_W'(N_STRIPS - 1));

`ifdef SCAN_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_stay;

  // Counts only while the handshake phase is stuck; any transition restarts it.
  assign wdog_stay = !abort && (((state == S_FIRE) && pulser_ready) ||
                                ((state == S_RELEASE) && !pulser_ready));
  assign wdog_trip = wdog_stay && (wdog_cnt == WDOG_W'(WDOG_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wdog_cnt <= '0;
    else if (wdog_stay) wdog_cnt <= wdog_cnt + 1'b1;
    else                wdog_cnt <= '0;
  end
`else
  assign wdog_trip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      strip             <= '0;
      last_lat          <= '0;
      pulse_cnt         <= '0;
      pulse_last        <= '0;
      hs_lat            <= 1'b0;
      settle_cnt        <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      fire_pulse        <= 1'b0;
      errcnt_rst        <= 1'b0;
      active_strip_mask <= '0;
      halfstrips_expect <= '0;
    end else if (abort) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fire_pulse <= 1'b0;
      errcnt_rst <= 1'b0;
    end else begin
      done       <= 1'b0;
      errcnt_rst <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            strip             <= first_strip;
            // A reversed range collapses to the single first strip.
            last_lat          <= (first_strip > last_strip) ? first_strip : last_strip;
            pulse_last        <= (n_pulses == 16'd0) ? 16'd0 : n_pulses - 16'd1;
            hs_lat            <= hs_side;
            busy              <= 1'b1;
            errcnt_rst        <= 1'b1;
            active_strip_mask <= strip_mask(first_strip);
            halfstrips_expect <= expect_mask(first_strip, hs_side);
            state             <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          pulse_cnt  <= '0;
          fire_pulse <= 1'b1;
          state      <= S_FIRE;
        end
        S_FIRE: begin
          if (wdog_trip) begin
            fire_pulse <= 1'b0;
            state      <= S_REPORT;
          end else if (!pulser_ready) begin
            fire_pulse <= 1'b0;
            state      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (wdog_trip) begin
            state <= S_REPORT;
          end else if (pulser_ready) begin
            if (pulse_cnt == pulse_last) begin
              settle_cnt <= '0;
              state      <= S_SETTLE;
            end else begin
              pulse_cnt  <= pulse_cnt + 16'd1;
              fire_pulse <= 1'b1;
              state      <= S_FIRE;
            end
          end
        end
        S_SETTLE: begin
          if (settle_done) state <= S_REPORT;
          else             settle_cnt <= settle_cnt + 1'b1;
        end
        S_REPORT: begin
          if (res_valid && res_ready) begin
            if (last_of_scan) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              strip             <= strip + 1'b1;
              errcnt_rst        <= 1'b1;
              active_strip_mask <= strip_mask(strip + 1'b1);
              halfstrips_expect <= expect_mask(strip + 1'b1, hs_lat);
              state             <= S_CLEAR;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  scan_result_reg #(
    .RES_W(RES_W)
  ) u_result (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (abort),
    .load       (settle_done || wdog_trip),
    .strip      (strip),
    .thr_cnt    (thresholds_errcnt),
    .off_cnt    (offsets_errcnt),
    .cmp_cnt    (compout_errcnt),
    .wdog       (wdog_trip),
    .ready      (res_ready),
    .valid      (res_valid),
    .res_strip  (res_strip),
    .res_thr_err(res_thr_err),
    .res_off_err(res_off_err),
    .res_cmp_err(res_cmp_err),
    .res_wdog   (res_wdog)
  );

endmodule

// File: tb/tb_comparator_scan_sequencer.sv
// Directed and randomized scans against a pulser/error-counter environment model
// and a per-strip record model derived from the scan rules.
module tb_comparator_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  first_strip = '0;
  logic [3:0]  last_strip = '0;
  logic [15:0] n_pulses = '0;
  logic        hs_side = 1'b0;
  logic        busy, done, fire_pulse, errcnt_rst;
  logic        pulser_ready = 1'b1;
  logic [31:0] active_strip_mask, halfstrips_expect;
  logic [31:0] thr_cnt = '0, off_cnt = '0, cmp_cnt = '0;
  logic        res_valid, res_wdog;
  logic        res_ready = 1'b1;
  logic [3:0]  res_strip;
  logic [15:0] res_thr_err, res_off_err, res_cmp_err;

  comparator_scan_sequencer #(
    .N_STRIPS(16), .RES_W(16), .SETTLE_CYC(4), .WDOG_CYC(255)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_strip(first_strip), .last_strip(last_strip), .n_pulses(n_pulses), .hs_side(hs_side),
    .busy(busy), .done(done), .fire_pulse(fire_pulse), .pulser_ready(pulser_ready),
    .active_strip_mask(active_strip_mask), .halfstrips_expect(halfstrips_expect),
    .errcnt_rst(errcnt_rst), .thresholds_errcnt(thr_cnt), .offsets_errcnt(off_cnt),
    .compout_errcnt(cmp_cnt), .res_valid(res_valid), .res_ready(res_ready),
    .res_strip(res_strip), .res_thr_err(res_thr_err), .res_off_err(res_off_err),
    .res_cmp_err(res_cmp_err), .res_wdog(res_wdog)
  );

  always #5 clk = ~clk;

  // Environment: pulser drops ready 3 cycles after fire, raises it 2 cycles after release;
  // error counters reload a base value on errcnt_rst and add a fixed step per pulse.
  logic        stuck = 1'b0;
  int unsigned pcnt = 0;
  logic        prev_fire_m = 1'b0;
  logic [31:0] base_thr = '0, base_off = '0, base_cmp = '0;
  logic [31:0] inc_thr = '0, inc_off = '0, inc_cmp = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_n || stuck) begin
      pulser_ready = 1'b1;
      pcnt = 0;
    end else if (fire_pulse && pulser_ready) begin
      pcnt++;
      if (pcnt >= 3) begin pulser_ready = 1'b0; pcnt = 0; end
    end else if (!fire_pulse && !pulser_ready) begin
      pcnt++;
      if (pcnt >= 2) begin pulser_ready = 1'b1; pcnt = 0; end
    end else begin
      pcnt = 0;
    end
    if (errcnt_rst) begin
      thr_cnt = base_thr; off_cnt = base_off; cmp_cnt = base_cmp;
    end else if (fire_pulse && !prev_fire_m) begin
      thr_cnt = thr_cnt + inc_thr; off_cnt = off_cnt + inc_off; cmp_cnt = cmp_cnt + inc_cmp;
    end
    prev_fire_m = fire_pulse;
  end

  typedef struct packed {
    logic [3:0]  strip;
    logic [15:0] thr, off, cmp;
    logic        wdog;
    logic [31:0] mask, hexp;
  } rec_t;

  rec_t        got_q[$];
  rec_t        prev_rec;
  logic        prev_hold = 1'b0, prev_fire_n = 1'b0;
  int unsigned fire_edges = 0, rst_pulses = 0, done_pulses = 0, hold_bad = 0, overlap_bad = 0;

  always @(negedge clk) begin
    rec_t cur;
    cur = '{strip: res_strip, thr: res_thr_err, off: res_off_err, cmp: res_cmp_err,
            wdog: res_wdog, mask: active_strip_mask, hexp: halfstrips_expect};
    if (prev_hold && (!res_valid || cur != prev_rec)) hold_bad++;
    if (res_valid && res_ready) got_q.push_back(cur);
    if (fire_pulse && !prev_fire_n) fire_edges++;
    if (errcnt_rst) rst_pulses++;
    if (done) done_pulses++;
    if (fire_pulse && (errcnt_rst || res_valid)) overlap_bad++;
    prev_fire_n = fire_pulse;
    prev_hold   = res_valid && !res_ready;
    prev_rec    = cur;
  end

  int unsigned n_tests = 0, n_fail = 0;

  task automatic step(input int unsigned n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

  // Compare queued records against the records the scan rules predict.
  task automatic check_records(input string tag, input int unsigned f, input int unsigned nstr,
                               input int unsigned npe, input logic hs, input logic wd);
    logic [31:0] three, one;
    three = 32'd3;
    one   = 32'd1;
    check({tag, "_nrec"}, got_q.size(), nstr);
    for (int unsigned i = 0; i < nstr && i < got_q.size(); i++) begin
      int unsigned s;
      s = f + i;
      check({tag, "_strip"}, {28'd0, got_q[i].strip}, s);
      check({tag, "_thr"}, {16'd0, got_q[i].thr}, {16'd0, sat16(base_thr + npe * inc_thr)});
      check({tag, "_off"}, {16'd0, got_q[i].off}, {16'd0, sat16(base_off + npe * inc_off)});
      check({tag, "_cmp"}, {16'd0, got_q[i].cmp}, {16'd0, sat16(base_cmp + npe * inc_cmp)});
      check({tag, "_wdog"}, {31'd0, got_q[i].wdog}, {31'd0, wd});
      check({tag, "_mask"}, got_q[i].mask, three << (2 * s));
      check({tag, "_hexp"}, got_q[i].hexp, one << (2 * s + hs));
    end
  endtask

  task automatic run_scan(input string tag, input logic [3:0] f, input logic [3:0] l,
                          input logic [15:0] np, input logic hs, input bit disturb);
    int unsigned fe0, r0, d0, t, npe, nstr;
    got_q.delete();
    fe0 = fire_edges; r0 = rst_pulses; d0 = done_pulses;
    first_strip = f; last_strip = l; n_pulses = np; hs_side = hs;
    start = 1'b1; step(); start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 1);
    if (disturb) begin
      step(3);
      first_strip = 4'($urandom); last_strip = 4'($urandom);
      n_pulses = 16'($urandom_range(0, 9)); hs_side = 1'($urandom);
      start = 1'b1; step(); start = 1'b0;
    end
    t = 0;
    while (!done && t < 20000) begin step(); t++; end
    check({tag, "_done_seen"}, {31'd0, done}, 1);
    step();
    check({tag, "_busy_end"}, {31'd0, busy}, 0);
    check({tag, "_done_1cyc"}, {31'd0, done}, 0);
    npe  = (np == 16'd0) ? 1 : int'(np);
    nstr = (f > l) ? 1 : int'(l) - int'(f) + 1;
    check_records(tag, f, nstr, npe, hs, 1'b0);
    check({tag, "_fires"}, fire_edges - fe0, nstr * npe);
    check({tag, "_clears"}, rst_pulses - r0, nstr);
    check({tag, "_dones"}, done_pulses - d0, 1);
  endtask

  initial begin
    int unsigned t, fc, fe0, d0, q0;
    logic [3:0]  rf, rl;
    logic [15:0] rn;
    rec_t        snap;

    step(2);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_fire", {31'd0, fire_pulse}, 0);
    check("rst_mask", active_strip_mask, 0);
    check("rst_hexp", halfstrips_expect, 0);
    check("rst_errcnt_rst", {31'd0, errcnt_rst}, 0);
    check("rst_valid", {31'd0, res_valid}, 0);
    check("rst_res", {res_strip, res_thr_err[11:0], res_off_err, res_wdog, res_cmp_err[2:0]}, 0);
    rst_n = 1'b1;
    step(2);
    check("idle_busy", {31'd0, busy}, 0);

    inc_off = 1;
    run_scan("plan", 4'd2, 4'd4, 16'd3, 1'b1, 1'b0);
    run_scan("off5", 4'd0, 4'd1, 16'd5, 1'b0, 1'b0);
    base_thr = 32'h0001_0003; inc_off = 0;
    run_scan("sat", 4'd10, 4'd10, 16'd2, 1'b0, 1'b0);
    base_thr = 32'h0000_FFFE; inc_thr = 1;
    run_scan("sat_edge", 4'd11, 4'd11, 16'd1, 1'b1, 1'b0);
    base_thr = 0; inc_thr = 0; inc_cmp = 2;
    run_scan("rev_range", 4'd9, 4'd3, 16'd2, 1'b0, 1'b0);
    run_scan("np0", 4'd15, 4'd15, 16'd0, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      base_thr = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 32'h0002_0000) : $urandom_range(0, 50);
      base_off = $urandom_range(0, 50);
      base_cmp = ($urandom_range(0, 2) == 0) ? 32'hFFFF_0000 : 32'd0;
      inc_thr = $urandom_range(0, 3); inc_off = $urandom_range(0, 3); inc_cmp = $urandom_range(0, 3);
      rf = 4'($urandom); rl = 4'($urandom); rn = 16'($urandom_range(0, 6));
      run_scan("rand", rf, rl, rn, 1'($urandom), 1'b1);
    end

    // Downstream back-pressure holds the record and stalls the scan.
    base_thr = 0; base_off = 0; base_cmp = 0; inc_thr = 0; inc_off = 1; inc_cmp = 0;
    got_q.delete();
    res_ready = 1'b0;
    first_strip = 4'd5; last_strip = 4'd6; n_pulses = 16'd2; hs_side = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    t = 0;
    while (!res_valid && t < 2000) begin step(); t++; end
    check("hold_valid_seen", {31'd0, res_valid}, 1);
    fe0 = fire_edges;
    step(20);
    check("hold_valid_kept", {31'd0, res_valid}, 1);
    check("hold_strip", {28'd0, res_strip}, 5);
    check("hold_off", {16'd0, res_off_err}, 2);
    check("hold_no_fire", fire_edges - fe0, 0);
    res_ready = 1'b1;
    step();
    check("hold_release_valid", {31'd0, res_valid}, 0);
    check("hold_next_clear", {31'd0, errcnt_rst}, 1);
    t = 0;
    while (!done && t < 2000) begin step(); t++; end
    check("hold_done", {31'd0, done}, 1);
    step();
    check_records("hold", 5, 2, 2, 1'b0, 1'b0);

    // Abort while strip 3 is in its release phase; a simultaneous start is ignored.
    got_q.delete();
    first_strip = 4'd2; last_strip = 4'd6; n_pulses = 16'd3; hs_side = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    t = 0;
    while (!(active_strip_mask == 32'h0000_00C0 && fire_pulse) && t < 2000) begin step(); t++; end
    while (fire_pulse && t < 2000) begin step(); t++; end
    check("abort_reached_release", {31'd0, busy && !fire_pulse && active_strip_mask == 32'h0000_00C0}, 1);
    d0 = done_pulses; q0 = got_q.size();
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    fe0 = fire_edges;
    check("abort_fire", {31'd0, fire_pulse}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_valid", {31'd0, res_valid}, 0);
    check("abort_prior_recs", q0, 1);
    step(60);
    check("abort_stays_idle", {31'd0, busy}, 0);
    check("abort_no_fire", fire_edges - fe0, 0);
    check("abort_no_done", done_pulses - d0, 0);
    check("abort_no_recs", got_q.size(), q0);

    // Asynchronous reset in the middle of a scan.
    first_strip = 4'd0; last_strip = 4'd15; n_pulses = 16'd4;
    start = 1'b1; step(); start = 1'b0;
    step(30);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_fire", {31'd0, fire_pulse}, 0);
    check("arst_mask", active_strip_mask, 0);
    check("arst_valid", {31'd0, res_valid}, 0);
    step();
    rst_n = 1'b1;
    step(2);
    run_scan("post_rst", 4'd1, 4'd1, 16'd1, 1'b0, 1'b0);

    // Pulser that never acknowledges.
    inc_off = 0;
    got_q.delete();
    stuck = 1'b1;
    first_strip = 4'd7; last_strip = 4'd8; n_pulses = 16'd1; hs_side = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    fc = 0; t = 0;
    while (!res_valid && t < 600) begin
      step(); t++;
      if (!res_valid && fire_pulse) fc++;
    end
`ifdef SCAN_WDOG_EN
    check("wdog_valid", {31'd0, res_valid}, 1);
    check("wdog_fire_cycles", fc, 255);
    check("wdog_flag", {31'd0, res_wdog}, 1);
    check("wdog_fire_off", {31'd0, fire_pulse}, 0);
    t = 0;
    while (!done && t < 2000) begin step(); t++; end
    check("wdog_done", {31'd0, done}, 1);
    step();
    check_records("wdog", 7, 2, 1, 1'b1, 1'b1);
`else
    check("stuck_no_valid", {31'd0, res_valid}, 0);
    check("stuck_fire_held", {31'd0, fire_pulse}, 1);
    check("stuck_fire_cycles", fc, 600);
    check("stuck_busy", {31'd0, busy}, 1);
    abort = 1'b1; step(); abort = 1'b0;
    check("stuck_abort_busy", {31'd0, busy}, 0);
    check("stuck_no_recs", got_q.size(), 0);
`endif
    stuck = 1'b0;
    step(4);

    check("hold_stable_all", hold_bad, 0);
    check("fire_exclusive", overlap_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
